data_mem_lsu: RTL and testbench

Parametrised data memory for the RISC-V core with byte/half/word access, load sign/zero extension, misalignment and range checking, and a valid/ready request handshake. It replaces the fixed word-only data memory and sits behind the MEM stage. It supports a configurable read latency so the array can later map onto registered block RAM with output pipelining.

---
 rtl/rv_mem_pkg.sv | 37 +++
 rtl/data_mem_lsu_if.sv | 28 ++
 rtl/data_mem_bank.sv | 36 +++
 rtl/data_mem_lsu.sv | 160 ++++++++++++++++
 tb/tb_data_mem_lsu.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the data memory load/store unit.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package rv_mem_pkg;

    // Access size encodings as carried on req_size.
    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ERR   = 2'd3
    } state_e;

    // Pull the addressed byte/half out of a full memory word and extend it.
    // Callers only pass aligned lanes, so a half always sits at lane 0 or 2.
    function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input size_e       size,
                                              input logic        uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SIZE_B:  ld_extend = uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            SIZE_H:  ld_extend = uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            SIZE_W:  ld_extend = word;
            default: ld_extend = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready handshake; rsp_valid is a one-cycle pulse with no ready.
// Ports: req_* request from master, req_ready from slave; rsp_* completion from slave.
interface data_mem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_bank.sv
// DEPTH_WORDS x 32 storage with per-byte write enables and a registered read port.
// Latency: write commits at the clock edge; read data valid the cycle after re.
// Backpressure: none; the caller decides when to read or write.
// Ports: clk; we (byte enables), re, idx (word index), wdata (lane-replicated), rdata (held until next re).
module data_mem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    // No reset on the array or read register so this maps onto block RAM.
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        // Read register only loads on an accepted read, so it holds the word
        // steady across the extra latency cycles.
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_lsu.sv
// Byte/half/word data memory with fault checking and load extension, one request in flight.
// Latency: stores and faults respond 1 cycle after accept, loads READ_LATENCY cycles after accept.
// Backpressure: req_ready only in IDLE; next request can be taken the cycle after rsp_valid.
// Ports: clk, rst_n (async active-low), bus (slave side of data_mem_lsu_if).
module data_mem_lsu
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_lsu_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH_WORDS) << 2;
    localparam logic [1:0]      CNT_LAST   = 2'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    size_e       size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic        uns_q, uns_d;

    size_e       req_size;
    logic [1:0]  req_lane;
    logic        accept;
    logic        size_bad, align_bad, range_bad, fault;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [3:0]  bank_we;
    logic        bank_re;
    logic [31:0] bank_rdata;

    assign req_size = size_e'(bus.req_size);
    assign req_lane = bus.req_addr[1:0];

    // rst_n gates ready so nothing is offered as accepted while reset is held.
    assign bus.req_ready = (state_q == IDLE) && rst_n;
    assign accept        = bus.req_valid && bus.req_ready;

    assign size_bad  = (req_size == SIZE_X);
    assign align_bad = ((req_size == SIZE_H) && req_lane[0]) ||
                       ((req_size == SIZE_W) && (req_lane != 2'b00));
    assign range_bad = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
    assign fault     = size_bad || align_bad || range_bad;

    // Byte enables and lane-replicated store data; replication lets the bank
    // pick each lane from the same bit positions regardless of offset.
    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = bus.req_wdata;
        case (req_size)
            SIZE_B: begin
                lane_be    = 4'b0001 << req_lane;
                lane_wdata = {4{bus.req_wdata[7:0]}};
            end
            SIZE_H: begin
                lane_be    = req_lane[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{bus.req_wdata[15:0]}};
            end
            SIZE_W: begin
                lane_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    assign bank_we = (accept && bus.req_we && !fault) ? lane_be : 4'b0000;
    assign bank_re = accept && !bus.req_we && !fault;

    data_mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .re    (bank_re),
        .idx   (bus.req_addr[IDX_W+1:2]),
        .wdata (lane_wdata),
        .rdata (bank_rdata)
    );

    // rsp_valid_d is asserted one cycle ahead of the cycle that must carry the
    // response so rsp_valid/rsp_err come straight from flops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        size_d      = size_q;
        lane_d      = lane_q;
        uns_d       = uns_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d = req_size;
                    lane_d = req_lane;
                    uns_d  = bus.req_unsigned;
                    cnt_d  = 2'd0;
                    if (fault) begin
                        state_d     = ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (bus.req_we) begin
                        state_d     = WRITE;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d     = READ;
                        rsp_valid_d = (READ_LATENCY == 1);
                    end
                end
            end
            WRITE, ERR: begin
                state_d = IDLE;
            end
            READ: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d       = cnt_q + 2'd1;
                    rsp_valid_d = ((cnt_q + 2'd1) == CNT_LAST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            size_q      <= SIZE_B;
            lane_q      <= 2'b00;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            uns_q       <= uns_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    // Extension runs off the held read register and the captured access
    // attributes; forced to zero outside a load response.
    assign bus.rsp_rdata = (rsp_valid_q && (state_q == READ)) ?
                           ld_extend(bank_rdata, lane_q, size_q, uns_q) : 32'h0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: two instances (read latency 1 and 3) driven by directed
// and random requests, checked every cycle against a byte-array reference model.
// Summary line reports total checks and errors.
module tb_data_mem_lsu;

    localparam int DEPTH = 1024;
    localparam int LIM   = DEPTH * 4;

    logic        clk;
    logic        rst_n_s  [2];
    logic        vld_s    [2];
    logic        we_s     [2];
    logic        uns_s    [2];
    logic [1:0]  size_s   [2];
    logic [31:0] addr_s   [2];
    logic [31:0] wdata_s  [2];
    logic        rdy_w    [2];
    logic        rv_w     [2];
    logic        re_w     [2];
    logic [31:0] rd_w     [2];

    data_mem_lsu_if #(.ADDR_W(32)) bus0 ();
    data_mem_lsu_if #(.ADDR_W(32)) bus1 ();

    assign bus0.req_valid    = vld_s[0];
    assign bus0.req_we       = we_s[0];
    assign bus0.req_size     = size_s[0];
    assign bus0.req_unsigned = uns_s[0];
    assign bus0.req_addr     = addr_s[0];
    assign bus0.req_wdata    = wdata_s[0];
    assign rdy_w[0]          = bus0.req_ready;
    assign rv_w[0]           = bus0.rsp_valid;
    assign re_w[0]           = bus0.rsp_err;
    assign rd_w[0]           = bus0.rsp_rdata;

    assign bus1.req_valid    = vld_s[1];
    assign bus1.req_we       = we_s[1];
    assign bus1.req_size     = size_s[1];
    assign bus1.req_unsigned = uns_s[1];
    assign bus1.req_addr     = addr_s[1];
    assign bus1.req_wdata    = wdata_s[1];
    assign rdy_w[1]          = bus1.req_ready;
    assign rv_w[1]           = bus1.rsp_valid;
    assign re_w[1]           = bus1.rsp_err;
    assign rd_w[1]           = bus1.rsp_rdata;

    data_mem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .READ_LATENCY(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n_s[0]),
        .bus   (bus0)
    );

    data_mem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .READ_LATENCY(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n_s[1]),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: byte-addressed memory plus "written" marks, and one
    // expected pending response per instance.
    logic [7:0]  mb   [2][LIM];
    bit          mk   [2][LIM];
    bit          pend [2] = '{0, 0};
    int          due  [2] = '{0, 0};
    logic [31:0] e_rd [2];
    bit          e_err[2];
    bit          e_kn [2];
    int          rsp_cnt [2] = '{0, 0};
    logic [31:0] last_rd [2];
    logic        last_err[2];

    int checks = 0;
    int errors = 0;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mword(input int d, input int a);
        return {mb[d][a+3], mb[d][a+2], mb[d][a+1], mb[d][a]};
    endfunction

    // Decide the response for the request about to be accepted and apply any store.
    task automatic model_accept(input int d);
        int          n;
        int          a;
        bit          flt;
        logic [31:0] v;
        n   = (size_s[d] == 2'b00) ? 1 : (size_s[d] == 2'b01) ? 2 : 4;
        flt = (size_s[d] == 2'b11) || (addr_s[d] % n != 0) || (addr_s[d] >= 32'(LIM));
        pend[d]  = 1;
        e_err[d] = flt;
        e_rd[d]  = 32'h0;
        e_kn[d]  = 1;
        due[d]   = cyc + 1;
        if (!flt) begin
            a = int'(addr_s[d]);
            if (we_s[d]) begin
                for (int i = 0; i < n; i++) begin
                    mb[d][a+i] = 8'(wdata_s[d] >> (8*i));
                    mk[d][a+i] = 1;
                end
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) begin
                    v = v | (32'(mb[d][a+i]) << (8*i));
                    if (!mk[d][a+i]) e_kn[d] = 0;
                end
                if (!uns_s[d] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                e_rd[d] = v;
                due[d]  = cyc + lat(d);
            end
        end
    endtask

    // Single compare process: every cycle, both instances.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit ev;
            bit erdy;
            if (!rst_n_s[d]) begin
                chk("rst_ready", d, {31'b0, rdy_w[d]}, 32'h0);
                chk("rst_valid", d, {31'b0, rv_w[d]}, 32'h0);
                chk("rst_err",   d, {31'b0, re_w[d]}, 32'h0);
                chk("rst_rdata", d, rd_w[d], 32'h0);
                pend[d] = 0;
            end else begin
                erdy = !pend[d];
                ev   = pend[d] && (cyc == due[d]);
                chk("req_ready", d, {31'b0, rdy_w[d]}, {31'b0, erdy});
                chk("rsp_valid", d, {31'b0, rv_w[d]}, {31'b0, ev});
                if (ev) begin
                    chk("rsp_err", d, {31'b0, re_w[d]}, {31'b0, e_err[d]});
                    if (e_kn[d]) chk("rsp_rdata", d, rd_w[d], e_rd[d]);
                    rsp_cnt[d]++;
                    last_rd[d]  = rd_w[d];
                    last_err[d] = re_w[d];
                    pend[d]     = 0;
                end else begin
                    chk("idle_rdata", d, rd_w[d], 32'h0);
                    chk("idle_err",   d, {31'b0, re_w[d]}, 32'h0);
                end
                if (vld_s[d] && erdy) model_accept(d);
            end
        end
    end

    // Present a request and hold it until accepted; returns #1 after the accept edge
    // with req_valid still high.
    task automatic send(input int d, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
        bit ok;
        we_s[d] = we; size_s[d] = sz; uns_s[d] = uns; addr_s[d] = a; wdata_s[d] = wd;
        vld_s[d] = 1'b1;
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (rdy_w[d]) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut%0d: req_ready stayed 0, expected 1", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        vld_s[d] = 1'b0;
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    task automatic req_chk(input string name, input int d, input bit we, input logic [1:0] sz,
                           input bit uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit exp_err);
        int c0;
        bit got;
        c0 = rsp_cnt[d];
        send(d, we, sz, uns, a, wd);
        vld_s[d] = 1'b0;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk);
            if (rsp_cnt[d] != c0) got = 1;
        end
        #1;
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout dut%0d: no rsp_valid, expected one", name, d);
        end else begin
            chk({name, "_rdata"}, d, last_rd[d], exp_rd);
            chk({name, "_err"},   d, {31'b0, last_err[d]}, {31'b0, exp_err});
        end
    endtask

    task automatic run(input int d);
        int          c0;
        int          n;
        int          r;
        logic [1:0]  sz;
        logic [31:0] a;
        // Directed sequence with hand-computed results.
        req_chk("sw0",      d, 1, 2'b10, 0, 32'h0,    32'hCAFEF00D, 32'h0, 0);
        req_chk("sw10",     d, 1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0, 0);
        req_chk("lw10",     d, 0, 2'b10, 0, 32'h10,   32'h0, 32'hDEADBEEF, 0);
        req_chk("sb13",     d, 1, 2'b00, 0, 32'h13,   32'hAAAAAA80, 32'h0, 0);
        req_chk("lb13",     d, 0, 2'b00, 0, 32'h13,   32'h0, 32'hFFFFFF80, 0);
        req_chk("lbu13",    d, 0, 2'b00, 1, 32'h13,   32'h0, 32'h00000080, 0);
        req_chk("lw10_b",   d, 0, 2'b10, 0, 32'h10,   32'h0, 32'h80ADBEEF, 0);
        req_chk("sh12",     d, 1, 2'b01, 0, 32'h12,   32'h55551234, 32'h0, 0);
        req_chk("lh12",     d, 0, 2'b01, 0, 32'h12,   32'h0, 32'h00001234, 0);
        req_chk("lh11",     d, 0, 2'b01, 0, 32'h11,   32'h0, 32'h0, 1);
        req_chk("lw10_h",   d, 0, 2'b10, 0, 32'h10,   32'h0, 32'h1234BEEF, 0);
        req_chk("lw1000",   d, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1);
        req_chk("size11",   d, 0, 2'b11, 0, 32'h0,    32'h0, 32'h0, 1);
        req_chk("sw1000",   d, 1, 2'b10, 0, 32'h1000, 32'hFFFFFFFF, 32'h0, 1);
        req_chk("lw0",      d, 0, 2'b10, 0, 32'h0,    32'h0, 32'hCAFEF00D, 0);
        req_chk("lhu_neg",  d, 0, 2'b01, 1, 32'h2,    32'h0, 32'h0000CAFE, 0);
        req_chk("lh_neg",   d, 0, 2'b01, 0, 32'h2,    32'h0, 32'hFFFFCAFE, 0);
        req_chk("sw_last",  d, 1, 2'b10, 0, 32'hFFC,  32'h01020304, 32'h0, 0);
        req_chk("lb_last",  d, 0, 2'b00, 0, 32'hFFF,  32'h0, 32'h00000001, 0);
        chk("model_pin10", d, mword(d, 'h10), 32'h1234BEEF);
        chk("model_pin0",  d, mword(d, 'h0),  32'hCAFEF00D);

        if (d == 1) begin
            // Three back-to-back loads with req_valid held high.
            c0 = rsp_cnt[d];
            send(d, 0, 2'b10, 0, 32'h10, 32'h0);
            send(d, 0, 2'b10, 0, 32'h0,  32'h0);
            send(d, 0, 2'b10, 0, 32'h10, 32'h0);
            idle(d, 5);
            chk("b2b_count", d, 32'(rsp_cnt[d] - c0), 32'd3);
            chk("b2b_last",  d, last_rd[d], 32'h1234BEEF);
            // Reset pulse in the middle of a load.
            c0 = rsp_cnt[d];
            send(d, 0, 2'b10, 0, 32'h10, 32'h0);
            vld_s[d] = 1'b0;
            @(posedge clk); #1;
            rst_n_s[d] = 1'b0;
            @(posedge clk); #1;
            rst_n_s[d] = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            chk("rst_no_rsp", d, 32'(rsp_cnt[d] - c0), 32'd0);
            req_chk("post_rst_lw", d, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 0);
        end

        // Fill the random window and the top words so loads there are fully known.
        for (int w = 0; w < 16; w++) send(d, 1, 2'b10, 0, 32'(w*4), $urandom());
        for (int w = 0; w < 4; w++)  send(d, 1, 2'b10, 0, 32'(LIM - 16 + w*4), $urandom());
        idle(d, 2);

        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 75)      a = 32'($urandom_range(0, 63));
            else if (r < 88) a = 32'($urandom_range(LIM - 8, LIM + 7));
            else             a = 32'($urandom_range(0, 2*LIM));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            send(d, ($urandom_range(0, 2) == 0), sz, 1'($urandom_range(0, 1)), a, $urandom());
            idle(d, $urandom_range(0, 2));
        end
        idle(d, 10);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n_s[d] = 1'b1; vld_s[d] = 1'b0; we_s[d] = 1'b0; uns_s[d] = 1'b0;
            size_s[d] = 2'b00; addr_s[d] = 32'h0; wdata_s[d] = 32'h0;
        end
        #1;
        rst_n_s[0] = 1'b0;
        rst_n_s[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;
        fork
            run(0);
            run(1);
        join
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
